vga_timing_gen: RTL

Parametrised VGA raster timing generator, successor to the fixed-rate `vga` block. It adds a programmable pixel-clock divider, configurable sync polarities, explicit pixel coordinates, a run/stop control and a row-prefetch pulse with configurable lead. It sits between the system clock and the pixel pipeline (RLE decoder, palette, output registers) and drives all raster-dependent logic in the design.

---
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: programmable pixel divider, sync polarities, row prefetch strobe.
// Optional line-compare interrupt is built when the macro VGA_LINE_MATCH_EN is defined.

module vga_timing_gen #(
  parameter int   WIDTH     = 640,
  parameter int   HEIGHT    = 480,
  parameter int   HFRONT    = 16,
  parameter int   HSYNC     = 96,
  parameter int   HBACK     = 48,
  parameter int   VFRONT    = 10,
  parameter int   VSYNC     = 2,
  parameter int   VBACK     = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   PIX_DIV   = 1,
  parameter int   LEAD      = 32,
  localparam int  HTOTAL    = WIDTH + HFRONT + HSYNC + HBACK,
  localparam int  VTOTAL    = HEIGHT + VFRONT + VSYNC + VBACK,
  localparam int  XW        = (HTOTAL > 1) ? $clog2(HTOTAL) : 1,
  localparam int  YW        = (VTOTAL > 1) ? $clog2(VTOTAL) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          run,
`ifdef VGA_LINE_MATCH_EN
  input  logic [YW-1:0] match_line,
`endif
  output logic          pix_en,
  output logic [XW-1:0] x_pos,
  output logic [YW-1:0] y_pos,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          next_row,
  output logic          next_frame,
  output logic          fetch_row,
  output logic          line_irq
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(PIX_DIV - 1);
  localparam logic [XW-1:0] X_LAST = XW'(HTOTAL - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VTOTAL - 1);

  localparam int H_SYNC_BEG = WIDTH + HFRONT;
  localparam int H_SYNC_END = H_SYNC_BEG + HSYNC;
  localparam int V_SYNC_BEG = HEIGHT + VFRONT;
  localparam int V_SYNC_END = V_SYNC_BEG + VSYNC;
  localparam int X_FETCH    = HTOTAL - 1 - LEAD;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [XW-1:0] x_n;
  logic [YW-1:0] y_n;
  logic [31:0]   x_ext, y_ext;
  logic          pix_en_n, hsync_n, vsync_n, blank_n;
  logic          next_row_n, next_frame_n, fetch_row_n;

  // The first cycle after run rises only arms the generator, so the
  // divider starts counting one clk later and pix_en lands PIX_DIV clks out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = run ? ST_RUN : ST_IDLE;
    div_n   = '0;
    x_n     = '0;
    y_n     = '0;
    if (run && state == ST_RUN) begin
      div_n = div_cnt;
      x_n   = x_pos;
      y_n   = y_pos;
      if (div_cnt == D_LAST) begin
        div_n = '0;
        if (x_pos == X_LAST) begin
          x_n = '0;
          y_n = (y_pos == Y_LAST) ? '0 : y_pos + 1'b1;
        end else begin
          x_n = x_pos + 1'b1;
        end
      end else begin
        div_n = div_cnt + 1'b1;
      end
    end
  end

  assign x_ext = 32'(x_n);
  assign y_ext = 32'(y_n);

  // Outputs decode the next counter values so the registered versions line up with x_pos/y_pos.
  always_comb begin
    pix_en_n     = run && (div_n == D_LAST);
    hsync_n      = ~HSYNC_POL;
    vsync_n      = ~VSYNC_POL;
    blank_n      = 1'b1;
    next_row_n   = 1'b0;
    next_frame_n = 1'b0;
    fetch_row_n  = 1'b0;
    if (run) begin
      if (x_ext >= H_SYNC_BEG && x_ext < H_SYNC_END) hsync_n = HSYNC_POL;
      if (y_ext >= V_SYNC_BEG && y_ext < V_SYNC_END) vsync_n = VSYNC_POL;
      blank_n      = (x_ext >= WIDTH) || (y_ext >= HEIGHT);
      next_row_n   = pix_en_n && (x_n == X_LAST);
      next_frame_n = pix_en_n && (x_n == X_LAST) && (y_n == Y_LAST);
      fetch_row_n  = pix_en_n && (x_ext == X_FETCH) &&
                     ((y_n == Y_LAST) || (y_ext < HEIGHT - 1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      x_pos      <= '0;
      y_pos      <= '0;
      pix_en     <= 1'b0;
      hsync      <= ~HSYNC_POL;
      vsync      <= ~VSYNC_POL;
      blank      <= 1'b1;
      next_row   <= 1'b0;
      next_frame <= 1'b0;
      fetch_row  <= 1'b0;
    end else begin
      div_cnt    <= div_n;
      x_pos      <= x_n;
      y_pos      <= y_n;
      pix_en     <= pix_en_n;
      hsync      <= hsync_n;
      vsync      <= vsync_n;
      blank      <= blank_n;
      next_row   <= next_row_n;
      next_frame <= next_frame_n;
      fetch_row  <= fetch_row_n;
    end
  end

`ifdef VGA_LINE_MATCH_EN
  logic line_irq_n;

  // Out-of-range compare values can never equal y, so they simply never fire.
  always_comb begin
    line_irq_n = run && pix_en_n && (x_n == '0) && (y_n == match_line) &&
                 (32'(match_line) < VTOTAL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) line_irq <= 1'b0;
    else          line_irq <= line_irq_n;
  end
`else
  assign line_irq = 1'b0;
`endif

endmodule
